// File: rtl/usb_pkg.sv
// Shared USB constants: PIDs, PID classes, CRC polynomials/residuals and
// the payload limit used by the receive packet decoder.
package usb_pkg;

    // Token PIDs
    localparam logic [7:0] PID_OUT   = 8'hE1;
    localparam logic [7:0] PID_IN    = 8'h69;
    localparam logic [7:0] PID_SOF   = 8'hA5;
    localparam logic [7:0] PID_SETUP = 8'h2D;
    // Data PIDs
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;
    localparam logic [7:0] PID_DATA2 = 8'h87;
    localparam logic [7:0] PID_MDATA = 8'h0F;
    // Handshake PIDs
    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;
    localparam logic [7:0] PID_STALL = 8'h1E;
    localparam logic [7:0] PID_NYET  = 8'h96;

    typedef enum logic [1:0] {
        CLS_TOKEN,
        CLS_DATA,
        CLS_HSHK,
        CLS_BAD
    } pid_class_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TOKEN,
        ST_DATA,
        ST_HSHK,
        ST_DISCARD
    } state_t;

    // CRCs are shifted LSB-first from an all-ones seed; a clean packet
    // (data followed by its inverted CRC) leaves these residuals behind.
    localparam logic [4:0]  CRC5_POLY      = 5'h05;
    localparam logic [4:0]  CRC5_RESIDUAL  = 5'h0C;
    localparam logic [15:0] CRC16_POLY     = 16'h8005;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

    localparam int MAX_PAYLOAD = 1024;

    // Post-PID byte counter: payload plus two CRC bytes is the longest
    // legal packet; the counter parks one above that so it never wraps.
    localparam int                CNT_W      = 11;
    localparam logic [CNT_W-1:0]  CNT_MAX_OK = CNT_W'(MAX_PAYLOAD + 2);
    localparam logic [CNT_W-1:0]  CNT_SAT    = CNT_W'(MAX_PAYLOAD + 3);

    // A PID is only trusted when its check nibble is the complement of
    // its type nibble and it belongs to one of the three handled classes.
    function automatic pid_class_t pid_class(input logic [7:0] p);
        pid_class_t c;
        c = CLS_BAD;
        if (p[7:4] == ~p[3:0]) begin
            case (p)
                PID_OUT, PID_IN, PID_SOF, PID_SETUP:      c = CLS_TOKEN;
                PID_DATA0, PID_DATA1, PID_DATA2, PID_MDATA: c = CLS_DATA;
                PID_ACK, PID_NAK, PID_STALL, PID_NYET:    c = CLS_HSHK;
                default:                                  c = CLS_BAD;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/usb_crc_byte.sv
// One byte of a serial CRC LFSR, unrolled: the byte is consumed LSB first,
// each bit shifting the register left and folding in POLY on feedback.
module usb_crc_byte #(
    parameter int           W    = 16,
    parameter logic [W-1:0] POLY = '0
) (
    input  logic [W-1:0] crc_in,
    input  logic [7:0]   data,
    output logic [W-1:0] crc_out
);

    logic [W-1:0] stage [0:8];

    assign stage[0] = crc_in;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_bit
            assign stage[gi+1] = (stage[gi][W-1] ^ data[gi])
                               ? ({stage[gi][W-2:0], 1'b0} ^ POLY)
                               : {stage[gi][W-2:0], 1'b0};
        end
    endgenerate

    assign crc_out = stage[8];

endmodule

// File: rtl/usb_rx_pkt_decoder.sv
// Receive-side packet decoder: classifies each received packet by PID,
// checks token CRC5 / data CRC16, strips the data CRC through a two-byte
// holdback and reports tokens, payload, handshakes and dropped packets.
module usb_rx_pkt_decoder
    import usb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_active,
    input  logic        rx_error,
    output logic [23:0] token_in,
    output logic        token_in_strb,
    output logic [7:0]  pid,
    output logic [7:0]  data_in,
    output logic        data_in_strb,
    output logic        data_in_end,
    output logic        data_in_fail,
    output logic [7:0]  hs_pid,
    output logic        hs_strb,
    output logic        pkt_err
);

    state_t           state_reg, state_next;
    pid_class_t       rx_class;
    logic             rx_byte;
    logic [4:0]       crc5_reg, crc5_step;
    logic [15:0]      crc16_reg, crc16_step;
    logic [CNT_W-1:0] cnt_reg, cnt_inc;
    logic             err_reg;
    logic [23:0]      tok_reg;
    logic [7:0]       hold_old_reg, hold_new_reg;

    assign rx_byte  = rx_valid && rx_active;
    assign rx_class = pid_class(rx_data);
    assign cnt_inc  = (cnt_reg == CNT_SAT) ? cnt_reg : cnt_reg + CNT_W'(1);

    usb_crc_byte #(.W(5), .POLY(CRC5_POLY)) u_crc5 (
        .crc_in  (crc5_reg),
        .data    (rx_data),
        .crc_out (crc5_step)
    );

    usb_crc_byte #(.W(16), .POLY(CRC16_POLY)) u_crc16 (
        .crc_in  (crc16_reg),
        .data    (rx_data),
        .crc_out (crc16_step)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= ST_IDLE;
        else     state_reg <= state_next;
    end

    // Next state: class chosen on the PID byte, back to IDLE at EOP
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (rx_byte) begin
                    case (rx_class)
                        CLS_TOKEN: state_next = rx_error ? ST_DISCARD : ST_TOKEN;
                        CLS_DATA:  state_next = ST_DATA;
                        CLS_HSHK:  state_next = rx_error ? ST_DISCARD : ST_HSHK;
                        default:   state_next = ST_DISCARD;
                    endcase
                end
            end
            ST_TOKEN, ST_HSHK: begin
                if (!rx_active)    state_next = ST_IDLE;
                else if (rx_error) state_next = ST_DISCARD;
            end
            default: begin
                if (!rx_active) state_next = ST_IDLE;
            end
        endcase
    end

    // Per-packet accumulation and registered result strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc5_reg      <= '1;
            crc16_reg     <= '1;
            cnt_reg       <= '0;
            err_reg       <= 1'b0;
            tok_reg       <= '0;
            hold_old_reg  <= '0;
            hold_new_reg  <= '0;
            token_in      <= '0;
            token_in_strb <= 1'b0;
            pid           <= '0;
            data_in       <= '0;
            data_in_strb  <= 1'b0;
            data_in_end   <= 1'b0;
            data_in_fail  <= 1'b0;
            hs_pid        <= '0;
            hs_strb       <= 1'b0;
            pkt_err       <= 1'b0;
        end else begin
            token_in_strb <= 1'b0;
            data_in_strb  <= 1'b0;
            data_in_end   <= 1'b0;
            data_in_fail  <= 1'b0;
            hs_strb       <= 1'b0;
            pkt_err       <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    crc5_reg  <= '1;
                    crc16_reg <= '1;
                    cnt_reg   <= '0;
                    err_reg   <= 1'b0;
                    if (rx_byte) begin
                        tok_reg <= {rx_data, 16'h0000};
                        if (rx_class == CLS_DATA) begin
                            pid     <= rx_data;
                            err_reg <= rx_error;
                        end
                    end
                end
                ST_TOKEN: begin
                    if (!rx_active) begin
                        if (cnt_reg == CNT_W'(2) && crc5_reg == CRC5_RESIDUAL && !rx_error) begin
                            token_in      <= tok_reg;
                            token_in_strb <= 1'b1;
                        end else begin
                            pkt_err <= 1'b1;
                        end
                    end else if (rx_valid) begin
                        crc5_reg <= crc5_step;
                        tok_reg  <= {rx_data, tok_reg[23:8]};
                        cnt_reg  <= cnt_inc;
                    end
                end
                ST_DATA: begin
                    if (!rx_active) begin
                        if (!err_reg && !rx_error && cnt_reg >= CNT_W'(2) &&
                            cnt_reg <= CNT_MAX_OK && crc16_reg == CRC16_RESIDUAL)
                            data_in_end  <= 1'b1;
                        else
                            data_in_fail <= 1'b1;
                    end else begin
                        if (rx_error) err_reg <= 1'b1;
                        if (rx_valid) begin
                            crc16_reg    <= crc16_step;
                            cnt_reg      <= cnt_inc;
                            hold_new_reg <= rx_data;
                            hold_old_reg <= hold_new_reg;
                            // Two bytes already held: the oldest is payload, not CRC
                            if (cnt_reg >= CNT_W'(2) && !(err_reg || rx_error)) begin
                                data_in      <= hold_old_reg;
                                data_in_strb <= 1'b1;
                            end
                        end
                    end
                end
                ST_HSHK: begin
                    if (!rx_active) begin
                        if (cnt_reg == '0 && !rx_error) begin
                            hs_pid  <= tok_reg[23:16];
                            hs_strb <= 1'b1;
                        end else begin
                            pkt_err <= 1'b1;
                        end
                    end else if (rx_valid) begin
                        cnt_reg <= cnt_inc;
                    end
                end
                default: begin
                    if (!rx_active) pkt_err <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_rx_pkt_decoder.sv
// Self-checking bench for usb_rx_pkt_decoder: a table of directed packets,
// hand-written reset/idle/long-packet sequences, then randomized packets
// whose CRCs and expected outcomes come from a reflected-CRC packet model.
module tb_usb_rx_pkt_decoder;

    logic        clk, rst;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_active, rx_error;
    logic [23:0] token_in;
    logic        token_in_strb;
    logic [7:0]  pid, data_in, hs_pid;
    logic        data_in_strb, data_in_end, data_in_fail, hs_strb, pkt_err;

    usb_rx_pkt_decoder dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_active(rx_active), .rx_error(rx_error), .token_in(token_in),
        .token_in_strb(token_in_strb), .pid(pid), .data_in(data_in),
        .data_in_strb(data_in_strb), .data_in_end(data_in_end),
        .data_in_fail(data_in_fail), .hs_pid(hs_pid), .hs_strb(hs_strb),
        .pkt_err(pkt_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge
    int n_tok = 0, n_end = 0, n_fail = 0, n_hs = 0, n_perr = 0;
    int tok_cyc = 0, end_cyc = 0, fail_cyc = 0, hs_cyc = 0, perr_cyc = 0;
    logic [7:0] got_q[$];
    always @(negedge clk) begin
        if (!rst) begin
            if (token_in_strb) begin n_tok  <= n_tok + 1;  tok_cyc  <= cyc; end
            if (data_in_end)   begin n_end  <= n_end + 1;  end_cyc  <= cyc; end
            if (data_in_fail)  begin n_fail <= n_fail + 1; fail_cyc <= cyc; end
            if (hs_strb)       begin n_hs   <= n_hs + 1;   hs_cyc   <= cyc; end
            if (pkt_err)       begin n_perr <= n_perr + 1; perr_cyc <= cyc; end
            if (data_in_strb)  got_q.push_back(data_in);
        end
    end

    logic [7:0]  pkt [0:1099];
    logic [7:0]  exp_q[$];
    logic [23:0] model_tok = '0;
    int fall_cyc = 0;
    int s_tok, s_end, s_fail, s_hs, s_perr, s_q;

    logic [7:0] tok_pids [4] = '{8'hE1, 8'h69, 8'hA5, 8'h2D};
    logic [7:0] dat_pids [4] = '{8'hC3, 8'h4B, 8'h87, 8'h0F};
    logic [7:0] hs_pids  [4] = '{8'hD2, 8'h5A, 8'h1E, 8'h96};

    // Reference CRCs in the reflected (right-shifting) form; the result is
    // the inverted register, transmitted low bit / low byte first.
    function automatic logic [4:0] crc5_model(input logic [10:0] v);
        logic [4:0] c = 5'h1F;
        for (int b = 0; b < 11; b++)
            c = (c[0] ^ v[b]) ? ((c >> 1) ^ 5'h14) : (c >> 1);
        return ~c;
    endfunction

    function automatic logic [15:0] crc16_model(input int first, input int last);
        logic [15:0] c = 16'hFFFF;
        for (int i = first; i <= last; i++)
            for (int b = 0; b < 8; b++)
                c = (c[0] ^ pkt[i][b]) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        return ~c;
    endfunction

    function automatic int cls_of(input logic [7:0] p);
        for (int i = 0; i < 4; i++) begin
            if (p == tok_pids[i]) return 0;
            if (p == dat_pids[i]) return 1;
            if (p == hs_pids[i])  return 2;
        end
        return 3;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, " token_in"}, 32'(token_in), 0);
        chk({nm, " pid"}, 32'(pid), 0);
        chk({nm, " data_in"}, 32'(data_in), 0);
        chk({nm, " hs_pid"}, 32'(hs_pid), 0);
        chk({nm, " strobes"}, 32'({token_in_strb, data_in_strb, data_in_end,
                                   data_in_fail, hs_strb, pkt_err}), 0);
    endtask

    task automatic snap();
        s_tok = n_tok; s_end = n_end; s_fail = n_fail; s_hs = n_hs;
        s_perr = n_perr; s_q = got_q.size();
    endtask

    // Drive pkt[0..n-1] as one packet, optional rx_error on byte err_idx,
    // optional idle cycles between bytes, then EOP and an inter-packet gap.
    task automatic send_pkt(input int n, input int err_idx, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
                rx_active = 1'b1; rx_valid = 1'b0; rx_error = 1'b0;
                rx_data = 8'($urandom);
            end
            @(posedge clk); #1;
            rx_active = 1'b1; rx_valid = 1'b1;
            rx_error = (i == err_idx); rx_data = pkt[i];
        end
        @(posedge clk); #1;
        rx_active = 1'b0; rx_valid = 1'b0; rx_error = 1'b0;
        fall_cyc = cyc;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic expect_pkt(input string nm, input int e_tok, input int e_end,
                              input int e_fail, input int e_hs, input logic [7:0] e_hsv,
                              input int e_perr, input int e_pidchk, input logic [7:0] e_pid,
                              input bit prefix);
        int got_n;
        int bad;
        chk({nm, " token_in_strb count"}, n_tok - s_tok, e_tok);
        chk({nm, " token_in"}, 32'(token_in), 32'(model_tok));
        chk({nm, " data_in_end count"}, n_end - s_end, e_end);
        chk({nm, " data_in_fail count"}, n_fail - s_fail, e_fail);
        chk({nm, " hs_strb count"}, n_hs - s_hs, e_hs);
        chk({nm, " pkt_err count"}, n_perr - s_perr, e_perr);
        if (e_tok > 0)  chk({nm, " token_in_strb cycle"}, tok_cyc, fall_cyc + 1);
        if (e_end > 0)  chk({nm, " data_in_end cycle"}, end_cyc, fall_cyc + 1);
        if (e_fail > 0) chk({nm, " data_in_fail cycle"}, fail_cyc, fall_cyc + 1);
        if (e_perr > 0) chk({nm, " pkt_err cycle"}, perr_cyc, fall_cyc + 1);
        if (e_hs > 0) begin
            chk({nm, " hs_pid"}, 32'(hs_pid), 32'(e_hsv));
            chk({nm, " hs_strb cycle"}, hs_cyc, fall_cyc + 1);
        end
        if (e_pidchk > 0) chk({nm, " pid"}, 32'(pid), 32'(e_pid));
        got_n = got_q.size() - s_q;
        if (prefix) chk({nm, " data count not above payload"}, 32'(got_n <= exp_q.size()), 1);
        else        chk({nm, " data count"}, got_n, exp_q.size());
        bad = -1;
        for (int i = 0; i < got_n && i < exp_q.size(); i++)
            if (bad < 0 && got_q[s_q + i] !== exp_q[i]) bad = i;
        tests++;
        if (bad >= 0) begin
            fails++;
            $display("FAIL %s data byte %0d: got %h, expected %h", nm, bad,
                     got_q[s_q + bad], exp_q[bad]);
        end
        $display("[TB] %s: tok=%0d end=%0d fail=%0d hs=%0d pkt_err=%0d bytes=%0d",
                 nm, n_tok - s_tok, n_end - s_end, n_fail - s_fail, n_hs - s_hs,
                 n_perr - s_perr, got_n);
    endtask

    typedef struct {
        string       name;
        int          len;
        logic [95:0] bytes;     // byte i at [8*i +: 8]
        int          err_idx;
        int          e_tok, e_end, e_fail, e_hs, e_perr, e_data_n;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    int n, err, kind, mut, plen, bi, e_tok, e_end, e_fail, e_hs, e_perr;
    bit prefix, gaps;
    logic [7:0]  p;
    logic [15:0] f, c;

    initial begin
        vecs[0] = '{"setup token",     3,  96'h10002D,                 -1, 1, 0, 0, 0, 0, 0};
        vecs[1] = '{"bad crc5 token",  3,  96'h11002D,                 -1, 0, 0, 0, 0, 1, 0};
        vecs[2] = '{"data0 setup",     11, 96'h94DD0040000001000680C3, -1, 0, 1, 0, 0, 0, 8};
        vecs[3] = '{"zero-len data1",  3,  96'h00004B,                 -1, 0, 1, 0, 0, 0, 0};
        vecs[4] = '{"data1 rx_error",  3,  96'h00004B,                  1, 0, 0, 1, 0, 0, 0};
        vecs[5] = '{"ack",             1,  96'hD2,                     -1, 0, 0, 0, 1, 0, 0};
        vecs[6] = '{"invalid pid 2e",  4,  96'h0010002E,               -1, 0, 0, 0, 0, 1, 0};
        vecs[7] = '{"one-byte data",   2,  96'h00C3,                   -1, 0, 0, 1, 0, 0, 0};
        vecs[8] = '{"long handshake",  2,  96'h00D2,                   -1, 0, 0, 0, 0, 1, 0};
        vecs[9] = '{"unhandled pid",   3,  96'h0000B4,                 -1, 0, 0, 0, 0, 1, 0};

        rst = 1'b1; rx_data = '0; rx_valid = 1'b0; rx_active = 1'b0; rx_error = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed table
        for (int r = 0; r < NV; r++) begin
            for (int j = 0; j < vecs[r].len; j++) pkt[j] = vecs[r].bytes[8*j +: 8];
            exp_q.delete();
            for (int j = 1; j <= vecs[r].e_data_n; j++) exp_q.push_back(pkt[j]);
            if (vecs[r].e_tok > 0) model_tok = {pkt[2], pkt[1], pkt[0]};
            snap();
            send_pkt(vecs[r].len, vecs[r].err_idx, 1'b0);
            expect_pkt(vecs[r].name, vecs[r].e_tok, vecs[r].e_end, vecs[r].e_fail,
                       vecs[r].e_hs, pkt[0], vecs[r].e_perr,
                       vecs[r].e_end + vecs[r].e_fail, pkt[0], 1'b0);
        end

        // rx_valid with rx_active low must be ignored
        snap();
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            rx_active = 1'b0; rx_valid = 1'b1; rx_data = 8'hD2;
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        expect_pkt("valid without active", 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 1'b0);

        // Longest legal payload, then one byte too many
        for (int k = 0; k < 2; k++) begin
            plen = 1024 + k;
            pkt[0] = 8'h87;
            for (int j = 1; j <= plen; j++) pkt[j] = 8'($urandom);
            c = crc16_model(1, plen);
            pkt[plen + 1] = c[7:0];
            pkt[plen + 2] = c[15:8];
            exp_q.delete();
            for (int j = 1; j <= plen; j++) exp_q.push_back(pkt[j]);
            snap();
            send_pkt(plen + 3, -1, 1'b0);
            if (k == 0) expect_pkt("payload 1024", 0, 1, 0, 0, 8'h00, 0, 1, 8'h87, 1'b0);
            else        expect_pkt("payload 1025", 0, 0, 1, 0, 8'h00, 0, 1, 8'h87, 1'b1);
        end

        // Reset in the middle of a data packet, then a clean SETUP token
        for (int j = 0; j < 11; j++) pkt[j] = vecs[2].bytes[8*j +: 8];
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            rx_active = 1'b1; rx_valid = 1'b1; rx_data = pkt[i];
        end
        #2;
        rst = 1'b1;
        #1;
        chk_zero("reset mid-packet");
        @(posedge clk); #1;
        rx_active = 1'b0; rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_tok = 24'h10002D;
        pkt[0] = 8'h2D; pkt[1] = 8'h00; pkt[2] = 8'h10;
        exp_q.delete();
        snap();
        send_pkt(3, -1, 1'b0);
        expect_pkt("setup after reset", 1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 1'b0);

        // Randomized packets against the model
        for (int t = 0; t < 60; t++) begin
            kind = $urandom_range(0, 3);
            mut  = $urandom_range(0, 3);
            gaps = 1'($urandom_range(0, 1));
            err = -1; prefix = 1'b0;
            e_tok = 0; e_end = 0; e_fail = 0; e_hs = 0; e_perr = 0;
            exp_q.delete();
            case (kind)
                0: begin
                    pkt[0] = tok_pids[$urandom_range(0, 3)];
                    f[10:0]  = 11'($urandom);
                    f[15:11] = crc5_model(f[10:0]);
                    pkt[1] = f[7:0]; pkt[2] = f[15:8]; n = 3;
                    if (mut == 1) begin
                        bi = $urandom_range(8, 23);
                        pkt[bi/8] = pkt[bi/8] ^ (8'h01 << (bi % 8));
                        e_perr = 1;
                    end else if (mut == 2) begin
                        err = $urandom_range(0, 2); e_perr = 1;
                    end else if (mut == 3) begin
                        pkt[3] = 8'($urandom); n = 4; e_perr = 1;
                    end else begin
                        model_tok = {pkt[2], pkt[1], pkt[0]}; e_tok = 1;
                    end
                end
                1: begin
                    pkt[0] = dat_pids[$urandom_range(0, 3)];
                    plen = $urandom_range(0, 16);
                    for (int j = 1; j <= plen; j++) pkt[j] = 8'($urandom);
                    c = crc16_model(1, plen);
                    pkt[plen + 1] = c[7:0]; pkt[plen + 2] = c[15:8];
                    n = plen + 3;
                    if (mut == 1) begin
                        bi = $urandom_range(8, 8*n - 1);
                        pkt[bi/8] = pkt[bi/8] ^ (8'h01 << (bi % 8));
                        e_fail = 1;
                    end else if (mut == 2) begin
                        err = $urandom_range(0, n - 1); e_fail = 1; prefix = 1'b1;
                    end else begin
                        e_end = 1;
                    end
                    for (int j = 1; j <= plen; j++) exp_q.push_back(pkt[j]);
                end
                2: begin
                    pkt[0] = hs_pids[$urandom_range(0, 3)]; n = 1;
                    if (mut == 1) begin
                        pkt[1] = 8'($urandom); n = 2; e_perr = 1;
                    end else if (mut == 2) begin
                        err = 0; e_perr = 1;
                    end else begin
                        e_hs = 1;
                    end
                end
                default: begin
                    p = 8'h00;
                    for (int k = 0; k < 100 && cls_of(p) != 3; k++) p = 8'($urandom);
                    pkt[0] = p;
                    n = $urandom_range(1, 4);
                    for (int j = 1; j < n; j++) pkt[j] = 8'($urandom);
                    e_perr = 1;
                end
            endcase
            snap();
            send_pkt(n, err, gaps);
            expect_pkt($sformatf("random %0d kind %0d mut %0d", t, kind, mut),
                       e_tok, e_end, e_fail, e_hs, pkt[0], e_perr,
                       (kind == 1) ? 1 : 0, pkt[0], prefix);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
